// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
// Optional feature macro used by the arbiter: UIO_ARB_TIMEOUT_EN.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } arb_state_e;

    localparam logic [7:0] OE_OFF    = 8'h00;
    localparam int         NREQ_MAX  = 8;
    localparam int         OWN_W_MAX = $clog2(NREQ_MAX);
    localparam int         TURN_W    = 3;

    // Owner index width for a given requester count; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_owner, wrapping.
module uio_bus_arbiter_rr_pick
    import uio_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [NREQ-1:0] pick_oh,
    output logic [IW-1:0]   pick_idx,
    output logic            pick_any
);

    logic found;

    // Offset 1..NREQ so last_owner itself is tried last.
    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last_owner) + k) % NREQ]) begin
                found                                  = 1'b1;
                pick_oh[(int'(last_owner) + k) % NREQ] = 1'b1;
                pick_idx                               = IW'((int'(last_owner) + k) % NREQ);
            end
        end
    end

    assign pick_any = |req;

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus with a forced all-input turnaround gap.
// Optional forced release after MAX_HOLD transfer cycles: define UIO_ARB_TIMEOUT_EN.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int         NREQ     = 4,
    parameter int         TURN_CYC = 1,
    parameter logic [7:0] OE_MASK  = 8'hFF,
    parameter int         MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   rw,
    input  logic [NREQ*8-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              timeout
);

    localparam int IW = idx_w(NREQ);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         last_q, last_d;
    logic                  wr_q, wr_d;
    logic [TURN_W-1:0]     turn_q, turn_d;
    logic [NREQ-1:0]       gnt_d;
    logic [7:0]            uio_out_d, uio_oe_d, rdata_d;
    logic                  rvalid_d, busy_d, xfer_go;
    logic [NREQ-1:0][7:0]  wbytes;
    logic [NREQ-1:0]       pick_oh;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;

`ifdef UIO_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    assign wbytes = wdata;

    uio_bus_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req        (req),
        .last_owner (last_q),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .pick_any   (pick_any)
    );

    // Outputs are computed for the next state and registered, so XFER outputs
    // appear exactly in the cycles the state register reads XFER.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wr_d      = wr_q;
        turn_d    = turn_q;
        gnt_d     = '0;
        uio_out_d = 8'h00;
        uio_oe_d  = OE_OFF;
        rdata_d   = rdata;
        rvalid_d  = 1'b0;
        xfer_go   = 1'b0;
`ifdef UIO_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        if (!ena) begin
            state_d = IDLE;
            rdata_d = 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_d = TURN;
                        owner_d = pick_idx;
                        wr_d    = |(rw & pick_oh);
                        turn_d  = '0;
                    end
                end
                TURN: begin
                    if (turn_q == TURN_W'(TURN_CYC - 1)) begin
                        state_d = XFER;
                        xfer_go = 1'b1;
`ifdef UIO_ARB_TIMEOUT_EN
                        hold_d  = HOLD_W'(1);
`endif
                    end else begin
                        turn_d = turn_q + 1'b1;
                    end
                end
                XFER: begin
                    if (!req[owner_q]) begin
                        state_d = IDLE;
                        last_d  = owner_q;
`ifdef UIO_ARB_TIMEOUT_EN
                    end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
                        state_d   = IDLE;
                        last_d    = owner_q;
                        timeout_d = 1'b1;
                    end else begin
                        xfer_go = 1'b1;
                        hold_d  = hold_q + 1'b1;
                    end
`else
                    end else begin
                        xfer_go = 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end

        if (xfer_go) begin
            gnt_d[owner_q] = 1'b1;
            if (wr_q) begin
                uio_out_d = wbytes[owner_q];
                uio_oe_d  = OE_MASK;
            end else begin
                rdata_d  = uio_in;
                rvalid_d = 1'b1;
            end
        end
        busy_d = (state_d != IDLE);
    end

    // Async reset clears gnt/uio_oe immediately, even mid-transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            wr_q    <= 1'b0;
            turn_q  <= '0;
            gnt     <= '0;
            uio_out <= 8'h00;
            uio_oe  <= OE_OFF;
            rdata   <= 8'h00;
            rvalid  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            turn_q  <= turn_d;
            gnt     <= gnt_d;
            uio_out <= uio_out_d;
            uio_oe  <= uio_oe_d;
            rdata   <= rdata_d;
            rvalid  <= rvalid_d;
            busy    <= busy_d;
        end
    end

`ifdef UIO_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter (NREQ=4, TURN_CYC=1, MAX_HOLD=4).
module tb_uio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [3:0]  rw;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;
    logic        timeout;

    int n_chk  = 0;
    int n_fail = 0;

    uio_bus_arbiter #(.NREQ(4), .TURN_CYC(1), .OE_MASK(8'hFF), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req     (req),
        .rw      (rw),
        .wdata   (wdata),
        .gnt     (gnt),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-safety invariants, sampled on the inactive edge.
    always @(negedge clk) begin
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("oe_without_gnt", 32'(gnt == 4'b0 && uio_oe != 8'h00), 32'd0);
    end

    initial begin
        rst = 1'b1; ena = 1'b1; req = 4'b0; rw = 4'b0; uio_in = 8'h00;
        wdata = {8'h44, 8'h33, 8'h22, 8'hA5};
        #12;
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_oe", uio_oe, 8'h00);
        chk("rst_out", uio_out, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_flags", {rvalid, busy, timeout}, 3'b000);
        tick(); rst = 1'b0;

        // Write by requester 0, then read by requester 2.
        req = 4'b0101; rw = 4'b0001;
        tick();
        chk("w_turn_gnt", gnt, 4'b0);
        chk("w_turn_oe", uio_oe, 8'h00);
        chk("w_turn_busy", busy, 1'b1);
        tick();
        chk("w_xfer_gnt", gnt, 4'b0001);
        chk("w_xfer_oe", uio_oe, 8'hFF);
        chk("w_xfer_out", uio_out, 8'hA5);
        chk("w_xfer_rvalid", rvalid, 1'b0);
        tick();
        chk("w_xfer2_out", uio_out, 8'hA5);
        req = 4'b0100; uio_in = 8'h3C;
        tick();
        chk("rel_gnt", gnt, 4'b0);
        chk("rel_oe", uio_oe, 8'h00);
        chk("rel_busy", busy, 1'b0);
        tick();
        chk("r_turn_oe", uio_oe, 8'h00);
        chk("r_turn_gnt", gnt, 4'b0);
        tick();
        chk("r_xfer_gnt", gnt, 4'b0100);
        chk("r_xfer_rvalid", rvalid, 1'b1);
        chk("r_xfer_rdata", rdata, 8'h3C);
        chk("r_xfer_oe", uio_oe, 8'h00);
        uio_in = 8'h5A;
        tick();
        chk("r_xfer2_rdata", rdata, 8'h5A);
        chk("r_xfer2_rvalid", rvalid, 1'b1);
        req = 4'b0;
        tick();
        chk("r_rel_gnt", gnt, 4'b0);
        chk("r_rel_rvalid", rvalid, 1'b0);
        chk("r_hold_rdata", rdata, 8'h5A);

        // Round-robin with every requester asserted.
        rst = 1'b1; #2; rst = 1'b0;
        rw = 4'b0000; req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                tick();
                chk($sformatf("rr%0d_c%0d_gnt", g, c), gnt, 4'b0001 << (g % 4));
            end
            req[g % 4] = 1'b0;
            tick();
            chk($sformatf("rr%0d_rel_gnt", g), gnt, 4'b0);
            req[g % 4] = 1'b1;
        end

        // ena dropped mid write; last owner stays 0 so 1 is granted again.
        rw = 4'b1111;
        tick(); tick();
        chk("ena_xfer_gnt", gnt, 4'b0010);
        chk("ena_xfer_out", uio_out, 8'h22);
        chk("ena_xfer_oe", uio_oe, 8'hFF);
        ena = 1'b0;
        tick();
        chk("ena_off_gnt", gnt, 4'b0);
        chk("ena_off_oe", uio_oe, 8'h00);
        chk("ena_off_busy", busy, 1'b0);
        tick();
        chk("ena_off2_busy", busy, 1'b0);
        ena = 1'b1;
        tick(); tick();
        chk("ena_resume_gnt", gnt, 4'b0010);

        // Asynchronous reset mid XFER.
        #1; rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 4'b0);
        chk("arst_oe", uio_oe, 8'h00);
        chk("arst_busy", busy, 1'b0);
        #1; rst = 1'b0;
        tick(); tick();
        chk("arst_first_gnt", gnt, 4'b0001);
        chk("arst_first_out", uio_out, 8'hA5);

        // Long hold by requester 1 with requester 2 pending.
        rst = 1'b1; #2; rst = 1'b0;
        rw = 4'b0000; req = 4'b0110;
        tick();
`ifdef UIO_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("to_c%0d_gnt", c), gnt, 4'b0010);
            chk($sformatf("to_c%0d_timeout", c), timeout, 1'b0);
        end
        tick();
        chk("to_rel_gnt", gnt, 4'b0);
        chk("to_pulse", timeout, 1'b1);
        tick();
        chk("to_pulse_end", timeout, 1'b0);
        tick();
        chk("to_next_gnt", gnt, 4'b0100);
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("hold_c%0d_gnt", c), gnt, 4'b0010);
            chk($sformatf("hold_c%0d_timeout", c), timeout, 1'b0);
        end
`endif
        req = 4'b0;
        tick(); tick();
        chk("end_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
